spi_slave_rx_tx: RTL and testbench
==================================

// Module: spi_slave_rx_tx
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the master in this library.
//  Samples sclk/ss/mosi asynchronously through 2-flop synchronisers into global_clk and drives miso.
//  Returns each received word on rx_data with a 1-cycle rx_valid pulse.
//  Takes outgoing words through a single-entry tx shadow register with a ready/load handshake.
// PARAMETERS
//  DATA_W     8      bits per SPI word
//  IDLE_WORD  8'hFF  word shifted out when the tx shadow is empty at word start (underrun)
// PORTS
//  global_clk  in   1       system clock; all logic is synchronous to its rising edge
//  reset       in   1       synchronous, active-high reset
//  sclk        in   1       SPI clock from master (async)
//  ss          in   1       slave select, active low (async)
//  mosi        in   1       master-out data (async)
//  miso        out  1       slave-out data
//  miso_oe     out  1       miso output enable; high only while selected
//  tx_data     in   DATA_W  next word to transmit
//  tx_load     in   1       write tx_data into shadow; ignored when tx_ready=0
//  tx_ready    out  1       shadow empty, tx_load accepted
//  rx_data     out  DATA_W  last complete received word; held until the next word completes
//  rx_valid    out  1       1-cycle pulse: rx_data updated
//  abort_err   out  1       1-cycle pulse: ss deasserted mid-word
//  tx_underrun out  1       1-cycle pulse: IDLE_WORD sent because the shadow was empty
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, abort_err=0, tx_underrun=0,
//   shadow empty, bit_cnt=0, state=WAIT_DESEL. Sync flops reset to sclk=0, ss=1, mosi=0.
//  Constraint: sclk high and low phases each >= 4 global_clk periods. Faster sclk is unsupported.
//  Edges: sclk_rise/sclk_fall/ss_fall/ss_rise are detected on synchronised signals (2 sync + 1 history flop).
//  FSM:
//   WAIT_DESEL: go to IDLE when synced ss=1. This blocks frames already in progress at reset.
//   IDLE: miso_oe=0, miso=0. On ss_fall: start word, go to SHIFT.
//   SHIFT: miso_oe=1.
//    - sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit_cnt++.
//    - sclk_fall: miso <= next tx_shift bit.
//    - On the sclk_rise giving bit_cnt==DATA_W: next cycle rx_data<=word, rx_valid=1, bit_cnt<=0,
//      start a new word (back-to-back words within one ss frame).
//    - On ss_rise: go to IDLE. If bit_cnt!=0, pulse abort_err, discard the partial word, no rx_valid.
//  Word start: tx_shift <= shadow if full, else IDLE_WORD with tx_underrun pulse.
//   Shadow becomes empty (tx_ready=1 next cycle). miso <= MSB of the loaded word in the same cycle.
//  Latency: rx_valid rises 3 global_clk cycles after the final sclk rising edge at the pin.
//  Simultaneous tx_load and word start:
//   - The word start uses the shadow value registered before that cycle.
//   - tx_load (if tx_ready was 1) fills the shadow for the next word.
//   - If the shadow was full, the consumed word leaves and the new one is written: tx_ready stays 0.
//  tx_load with tx_ready=0: ignored, shadow unchanged.
//  ss_rise and sclk_rise in the same cycle: ss_rise wins, the sclk edge is ignored.
//  Reset mid-frame: all state to reset values, partial data lost, shadow emptied, no pulses.
//  bit_cnt width $clog2(DATA_W)+1; it never exceeds DATA_W.
// CONFIGURATION
//  SPI_SLAVE_RX_OVERRUN_EN defined:
//   - Adds ports rx_ack (in, 1) and rx_overrun (out, 1, reset 0).
//   - rx_valid becomes a level held until rx_ack.
//   - If a word completes while rx_valid=1: rx_data is NOT overwritten and rx_overrun sets (sticky).
//   - rx_ack clears both rx_valid and rx_overrun. An ack in the same cycle as a new completion
//     accepts the new word with rx_valid=1.
//  Undefined: no rx_ack/rx_overrun ports, rx_valid is a 1-cycle pulse, rx_data always overwritten.
// TESTING
//  1. ss low, master sends 8'hA5 while shadow holds 8'h3C
//     -> rx_data=8'hA5 with one rx_valid pulse; master receives 8'h3C; tx_ready=1 after ss_fall.
//  2. Two words in one ss frame: 8'h12, 8'h34; shadow reloaded with 8'hC3 before word 2
//     -> two rx_valid pulses (12, 34); miso sends 3C then C3.
//  3. Shadow empty at ss_fall -> miso sends 8'hFF, one tx_underrun pulse, rx still correct.
//  4. ss raised after 5 sclk edges -> abort_err pulse, no rx_valid, rx_data keeps its old value,
//     next frame 8'h5A is received correctly.
//  5. reset asserted mid-word with ss held low -> no rx_valid until ss goes high, then a full new
//     frame 8'h81 is received; all outputs show reset values during reset.
//  6. SPI_SLAVE_RX_OVERRUN_EN: two words with no rx_ack -> rx_data=first word, rx_overrun=1;
//     rx_ack clears both.

Source files
------------

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first.
// sclk/ss/mosi are brought into global_clk through 2-flop synchronisers,
// and their edges are detected against a third history flop. Each received
// word appears on rx_data with rx_valid. Outgoing words pass through a
// single-entry shadow register (tx_ready/tx_load handshake).
//
// Optional feature macro: SPI_SLAVE_RX_OVERRUN_EN
//   defined   : adds rx_ack/rx_overrun. rx_valid is a level held until rx_ack;
//               a word that completes while rx_valid=1 is dropped and
//               rx_overrun is set (sticky until rx_ack).
//   undefined : rx_valid is a 1-cycle pulse and rx_data is always overwritten.
//
// Ports:
//   global_clk, reset        clock and synchronous active-high reset
//   sclk, ss, mosi           asynchronous SPI inputs (ss is active low)
//   miso, miso_oe            SPI output and its enable (enable high only while selected)
//   tx_data, tx_load         word to send and its write strobe
//   tx_ready                 shadow register is empty
//   rx_data, rx_valid        received word and its valid flag
//   abort_err                pulse: ss went high in the middle of a word
//   tx_underrun              pulse: IDLE_WORD was sent because the shadow was empty
//   rx_ack, rx_overrun       (SPI_SLAVE_RX_OVERRUN_EN only)
module spi_slave_rx_tx #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b1}}
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  input  logic              rx_ack,
  output logic              rx_overrun,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              abort_err,
  output logic              tx_underrun
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {WAIT_DESEL, IDLE, SHIFT} state_t;
  state_t state, state_n;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;
  logic [1:0] prime_cnt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, shadow;
  logic              shadow_full, underrun_pend;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, primed;
  logic word_done, word_start, abort, tx_accept;
  logic [DATA_W-1:0] rx_word, start_word;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign ss_fall   = ~ss_s2 & ss_d;
  assign ss_rise   = ss_s2 & ~ss_d;
  // The sync chain holds reset values (ss=1) for a few cycles after reset;
  // don't trust ss as deselected until it has been refilled from the pin,
  // otherwise a frame held low across reset would look like a fresh ss_fall.
  assign primed    = (prime_cnt == 2'd3);

  assign tx_ready   = ~shadow_full;
  assign tx_accept  = tx_load & ~shadow_full;
  assign rx_word    = {rx_shift[DATA_W-2:0], mosi_s2};
  // ss_rise wins over an sclk edge seen in the same cycle.
  assign word_done  = (state == SHIFT) & ~ss_rise & sclk_rise &
                      (bit_cnt == CNT_W'(DATA_W-1));
  assign word_start = ((state == IDLE) & ss_fall) | word_done;
  assign start_word = shadow_full ? shadow : IDLE_WORD;
  assign abort      = (state == SHIFT) & ss_rise & (bit_cnt != '0);

  always_ff @(posedge global_clk) begin
    if (reset) state <= WAIT_DESEL;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    miso_oe = 1'b0;
    case (state)
      WAIT_DESEL: if (primed && ss_s2 && ss_d) state_n = IDLE;
      IDLE:       if (ss_fall) state_n = SHIFT;
      SHIFT: begin
        miso_oe = 1'b1;
        if (ss_rise) state_n = IDLE;
      end
      default:    state_n = WAIT_DESEL;
    endcase
  end

  always_ff @(posedge global_clk) begin
    if (reset) begin
      {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
      {ss_s1, ss_s2, ss_d}       <= 3'b111;
      {mosi_s1, mosi_s2}         <= 2'b00;
      prime_cnt     <= '0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      shadow        <= '0;
      shadow_full   <= 1'b0;
      underrun_pend <= 1'b0;
      miso          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      abort_err     <= 1'b0;
      tx_underrun   <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      rx_overrun    <= 1'b0;
`endif
    end else begin
      {sclk_s2, sclk_s1} <= {sclk_s1, sclk};
      sclk_d             <= sclk_s2;
      {ss_s2, ss_s1}     <= {ss_s1, ss};
      ss_d               <= ss_s2;
      {mosi_s2, mosi_s1} <= {mosi_s1, mosi};
      if (!primed) prime_cnt <= prime_cnt + 2'd1;

      abort_err   <= abort;
      tx_underrun <= 1'b0;

      if (tx_accept) begin
        shadow      <= tx_data;
        shadow_full <= 1'b1;
      end

      case (state)
        SHIFT: begin
          if (ss_rise) begin
            bit_cnt       <= '0;
            miso          <= 1'b0;
            underrun_pend <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_word;
            bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            // Underrun is reported when the master actually clocks the idle
            // word, so a trailing word start at frame end stays silent.
            if (bit_cnt == '0 && underrun_pend) begin
              tx_underrun   <= 1'b1;
              underrun_pend <= 1'b0;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // The fall right after a word boundary keeps the freshly loaded MSB.
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            miso     <= tx_shift[DATA_W-2];
          end
        end
        default: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase

      // Word start consumes the shadow as registered before this cycle; a
      // same-cycle tx_load refills it for the following word.
      if (word_start) begin
        tx_shift      <= start_word;
        miso          <= start_word[DATA_W-1];
        underrun_pend <= ~shadow_full;
        shadow_full   <= tx_accept;
      end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (word_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
`else
      rx_valid <= word_done;
      if (word_done) rx_data <= rx_word;
`endif
    end
  end
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
module tb_spi_slave_rx_tx;
  logic       global_clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, abort_err, tx_underrun;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       auto_ack = 1'b1;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ab_cnt   = 0;
  int ur_cnt   = 0;
  logic vld_q  = 1'b0;
  logic [7:0] rx_q[$];

  spi_slave_rx_tx #(.DATA_W(8), .IDLE_WORD(8'hFF)) dut (
    .global_clk(global_clk), .reset(reset),
    .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    .rx_ack(rx_ack), .rx_overrun(rx_overrun),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid),
    .abort_err(abort_err), .tx_underrun(tx_underrun)
  );

  always #5 global_clk = ~global_clk;

  // Event monitor: words captured on each rx_valid rising edge, pulse counts.
  always @(negedge global_clk) begin
    if (rx_valid && !vld_q) rx_q.push_back(rx_data);
    vld_q <= rx_valid;
    if (abort_err)   ab_cnt <= ab_cnt + 1;
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    rx_ack <= auto_ack & rx_valid;
`endif
  end

  task automatic clks(input int n);
    repeat (n) @(negedge global_clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge global_clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge global_clk);
    tx_load = 1'b0;
  endtask

  // Mode-0 master: set mosi while sclk low, sample miso at the rising edge.
  task automatic xfer_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i];
      clks(4);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    clks(3);
    chk_cnt++; if ({miso, miso_oe} !== 2'b00) $display("FAIL reset_miso: got %b want 00", {miso, miso_oe}); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++; if ({rx_valid, abort_err, tx_underrun} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {rx_valid, abort_err, tx_underrun}); else pass_cnt++;
    reset = 1'b0;
    clks(6);
  endtask

  task automatic test_single();
    logic [7:0] mi;
    int base, ur0;
    base = rx_q.size(); ur0 = ur_cnt;
    load(8'h3C);
    chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL single_loaded: tx_ready got %b want 0", tx_ready); else pass_cnt++;
    ss = 1'b0;
    clks(6);
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL single_ready_after_ss: got %b want 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b1) $display("FAIL single_oe: got %b want 1", miso_oe); else pass_cnt++;
    xfer_bits(8'hA5, 7, mi);
    mosi = 1'b1;
    clks(4);
    sclk = 1'b1;
    mi = {mi[6:0], miso};
    clks(2);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_latency_early: rx_valid got %b want 0", rx_valid); else pass_cnt++;
    clks(1);
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL single_latency: rx_valid got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_rx: got %h want a5", rx_data); else pass_cnt++;
    clks(1);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_pulse_width: rx_valid got %b want 0", rx_valid); else pass_cnt++;
    clks(1);
    sclk = 1'b0;
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (mi !== 8'h3C) $display("FAIL single_miso_word: got %h want 3c", mi); else pass_cnt++;
    chk_cnt++; if (rx_q.size() !== base + 1) $display("FAIL single_rx_count: got %0d want %0d", rx_q.size(), base + 1); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL single_oe_off: got %b want 0", miso_oe); else pass_cnt++;
    chk_cnt++; if (ur_cnt !== ur0) $display("FAIL single_no_underrun: got %0d want %0d", ur_cnt, ur0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    int base;
    base = rx_q.size();
    load(8'h3C);
    ss = 1'b0;
    clks(6);
    load(8'hC3);
    chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL b2b_reload: tx_ready got %b want 0", tx_ready); else pass_cnt++;
    xfer_bits(8'h12, 8, mi1);
    xfer_bits(8'h34, 8, mi2);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (rx_q.size() !== base + 2) $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), base + 2); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h12) $display("FAIL b2b_rx0: got %h want 12", rx_q[base]); else pass_cnt++;
    chk_cnt++; if (rx_q[base+1] !== 8'h34) $display("FAIL b2b_rx1: got %h want 34", rx_q[base+1]); else pass_cnt++;
    chk_cnt++; if (mi1 !== 8'h3C) $display("FAIL b2b_miso0: got %h want 3c", mi1); else pass_cnt++;
    chk_cnt++; if (mi2 !== 8'hC3) $display("FAIL b2b_miso1: got %h want c3", mi2); else pass_cnt++;
    chk_cnt++; if (ab_cnt !== 0) $display("FAIL b2b_no_abort: got %0d want 0", ab_cnt); else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    int ur0;
    ur0 = ur_cnt;
    ss = 1'b0;
    clks(6);
    xfer_bits(8'h77, 8, mi);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (mi !== 8'hFF) $display("FAIL underrun_miso: got %h want ff", mi); else pass_cnt++;
    chk_cnt++; if (ur_cnt !== ur0 + 1) $display("FAIL underrun_pulses: got %0d want %0d", ur_cnt, ur0 + 1); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h77) $display("FAIL underrun_rx: got %h want 77", rx_data); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int base, ab0;
    base = rx_q.size(); ab0 = ab_cnt;
    ss = 1'b0;
    clks(6);
    xfer_bits(8'hF0, 5, mi);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (ab_cnt !== ab0 + 1) $display("FAIL abort_pulse: got %0d want %0d", ab_cnt, ab0 + 1); else pass_cnt++;
    chk_cnt++; if (rx_q.size() !== base) $display("FAIL abort_no_rx: got %0d want %0d", rx_q.size(), base); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h77) $display("FAIL abort_rx_held: got %h want 77", rx_data); else pass_cnt++;
    ss = 1'b0;
    clks(6);
    xfer_bits(8'h5A, 8, mi);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (rx_data !== 8'h5A) $display("FAIL abort_next_rx: got %h want 5a", rx_data); else pass_cnt++;
    chk_cnt++; if (ab_cnt !== ab0 + 1) $display("FAIL abort_once: got %0d want %0d", ab_cnt, ab0 + 1); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    int base;
    load(8'h99);
    ss = 1'b0;
    clks(6);
    xfer_bits(8'hE7, 3, mi);
    reset = 1'b1;
    clks(3);
    chk_cnt++; if ({miso, miso_oe, tx_ready} !== 3'b001) $display("FAIL rst_mid_tx: got %b want 001", {miso, miso_oe, tx_ready}); else pass_cnt++;
    chk_cnt++; if ({rx_data, rx_valid, abort_err, tx_underrun} !== 11'h000) $display("FAIL rst_mid_rx: got %h want 000", {rx_data, rx_valid, abort_err, tx_underrun}); else pass_cnt++;
    reset = 1'b0;
    base = rx_q.size();
    xfer_bits(8'hAA, 8, mi);
    clks(4);
    chk_cnt++; if (rx_q.size() !== base) $display("FAIL rst_mid_blocked: got %0d want %0d", rx_q.size(), base); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL rst_mid_oe: got %b want 0", miso_oe); else pass_cnt++;
    ss = 1'b1;
    clks(6);
    ss = 1'b0;
    clks(6);
    xfer_bits(8'h81, 8, mi);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (rx_q.size() !== base + 1) $display("FAIL rst_mid_count: got %0d want %0d", rx_q.size(), base + 1); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h81) $display("FAIL rst_mid_rx_word: got %h want 81", rx_data); else pass_cnt++;
  endtask

`ifdef SPI_SLAVE_RX_OVERRUN_EN
  task automatic test_overrun();
    logic [7:0] mi;
    auto_ack = 1'b0;
    ss = 1'b0;
    clks(6);
    xfer_bits(8'h11, 8, mi);
    xfer_bits(8'h22, 8, mi);
    clks(4);
    ss = 1'b1;
    clks(6);
    chk_cnt++; if (rx_data !== 8'h11) $display("FAIL overrun_data: got %h want 11", rx_data); else pass_cnt++;
    chk_cnt++; if ({rx_valid, rx_overrun} !== 2'b11) $display("FAIL overrun_flags: got %b want 11", {rx_valid, rx_overrun}); else pass_cnt++;
    auto_ack = 1'b1;
    clks(3);
    chk_cnt++; if ({rx_valid, rx_overrun} !== 2'b00) $display("FAIL overrun_ack: got %b want 00", {rx_valid, rx_overrun}); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    test_overrun();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
